// File: rtl/nibble_frame_packer.sv
// Packs WORDS_PER_FRAME consecutive 4-bit words into one wide frame with a
// running XOR parity word, and hands the frame off on a valid/ready port.
module nibble_frame_packer #(
    parameter int WORD_SIZE       = 4,
    parameter int WORDS_PER_FRAME = 8,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WORD_SIZE-1:0]                 in_data,
    output logic                                 frame_valid,
    input  logic                                 frame_ready,
    output logic [WORD_SIZE*WORDS_PER_FRAME-1:0] frame_data,
    output logic [WORD_SIZE-1:0]                 frame_parity,
    output logic [7:0]                           frame_count
);

    localparam int FRAME_W = WORD_SIZE * WORDS_PER_FRAME;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [FRAME_W-1:0]     r_acc;
    logic [WORD_SIZE-1:0]   r_parity;
    logic                   r_frame_valid;
    logic [FRAME_W-1:0]     r_frame_data;
    logic [WORD_SIZE-1:0]   r_frame_parity;
    logic [7:0]             r_frame_count;

    logic [FRAME_W-1:0]     w_acc_next;
    logic                   w_last;
    logic                   w_in_ready;

    function automatic logic [WORD_SIZE-1:0] parity_step(
        input logic [WORD_SIZE-1:0] acc,
        input logic [WORD_SIZE-1:0] word
    );
        return acc ^ word;
    endfunction

    // Accumulator with the incoming word dropped into the current slot.
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[int'(r_cnt)*WORD_SIZE +: WORD_SIZE] = in_data;
        w_last = (r_cnt == CNT_WIDTH'(WORDS_PER_FRAME - 1));
    end

    // Input backpressure: flush always wins, FULL only passes when the frame leaves.
    always_comb begin
        w_in_ready = 1'b0;
        if (flush) begin
            w_in_ready = 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: w_in_ready = 1'b1;
                ST_FULL:    w_in_ready = frame_ready;
                default:    w_in_ready = 1'b0;
            endcase
        end
    end

    // Collect/handoff state machine with all frame outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_COLLECT;
            r_cnt          <= '0;
            r_acc          <= '0;
            r_parity       <= '0;
            r_frame_valid  <= 1'b0;
            r_frame_data   <= '0;
            r_frame_parity <= '0;
            r_frame_count  <= 8'd0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (flush) begin
                        r_cnt    <= '0;
                        r_parity <= '0;
                    end else if (in_valid) begin
                        r_acc <= w_acc_next;
                        if (w_last) begin
                            r_frame_data   <= w_acc_next;
                            r_frame_parity <= parity_step(r_parity, in_data);
                            r_frame_valid  <= 1'b1;
                            r_cnt          <= '0;
                            r_parity       <= '0;
                            r_state        <= ST_FULL;
                        end else begin
                            r_cnt    <= r_cnt + CNT_WIDTH'(1);
                            r_parity <= parity_step(r_parity, in_data);
                        end
                    end
                end
                ST_FULL: begin
                    if (frame_ready) begin
                        r_frame_count <= r_frame_count + 8'd1;
                        r_frame_valid <= 1'b0;
                        r_state       <= ST_COLLECT;
                        // Word arriving with the handshake starts the next frame without a bubble.
                        if (in_valid && !flush) begin
                            r_acc[WORD_SIZE-1:0] <= in_data;
                            r_cnt                <= CNT_WIDTH'(1);
                            r_parity             <= in_data;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_COLLECT;
                    r_cnt         <= '0;
                    r_parity      <= '0;
                    r_frame_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign frame_valid  = r_frame_valid;
    assign frame_data   = r_frame_data;
    assign frame_parity = r_frame_parity;
    assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_nibble_frame_packer.sv
// Directed vector table plus hand-written async-reset and frame-count wrap sequences.
module tb_nibble_frame_packer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [31:0] frame_data;
    logic [3:0]  frame_parity;
    logic [7:0]  frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        iv;
        logic [3:0]  d;
        logic        fl;
        logic        fr;
        logic        e_ir;
        logic        e_fv;
        logic [31:0] e_fd;
        logic [3:0]  e_fp;
        logic [7:0]  e_fc;
    } vec_t;

    vec_t vq[$];

    nibble_frame_packer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .frame_parity (frame_parity),
        .frame_count  (frame_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [3:0] d, input logic fl, input logic fr,
                       input logic e_ir, input logic e_fv, input logic [31:0] e_fd,
                       input logic [3:0] e_fp, input logic [7:0] e_fc);
        vec_t v;
        v.iv = iv; v.d = d; v.fl = fl; v.fr = fr;
        v.e_ir = e_ir; v.e_fv = e_fv; v.e_fd = e_fd; v.e_fp = e_fp; v.e_fc = e_fc;
        vq.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [3:0] d, input logic fl, input logic fr);
        @(posedge clock);
        #1;
        in_valid = iv; in_data = d; flush = fl; frame_ready = fr;
    endtask

    initial begin
        logic [3:0] seq_c [7];
        seq_c = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};

        // Words 1..8 with frame_ready high.
        for (int i = 0; i < 8; i++) add(1'b1, 4'(i + 1), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 8'd0);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h87654321, 4'h8, 8'd0);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h87654321, 4'h8, 8'd1);
        // 16 continuous words, zero-bubble back-to-back frames.
        for (int i = 0; i < 8; i++) add(1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b0, 32'h87654321, 4'h8, 8'd1);
        add(1'b1, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1, 32'h76543210, 4'h0, 8'd1);
        for (int i = 9; i < 16; i++) add(1'b1, 4'(i), 1'b0, 1'b1, 1'b1, 1'b0, 32'h76543210, 4'h0, 8'd2);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFEDCBA98, 4'h0, 8'd2);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFEDCBA98, 4'h0, 8'd3);
        // Backpressure: 5 stalled cycles with 0xA pending, then joint accept.
        for (int i = 0; i < 8; i++) add(1'b1, 4'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 32'hFEDCBA98, 4'h0, 8'd3);
        for (int i = 0; i < 5; i++) add(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 32'h87654321, 4'h8, 8'd3);
        add(1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 32'h87654321, 4'h8, 8'd3);
        for (int i = 0; i < 7; i++) add(1'b1, seq_c[i], 1'b0, 1'b1, 1'b1, 1'b0, 32'h87654321, 4'h8, 8'd4);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h21FEDCBA, 4'h2, 8'd4);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h21FEDCBA, 4'h2, 8'd5);
        // Flush of a 3-word partial frame; 0x9 offered during flush is dropped.
        for (int i = 5; i < 8; i++) add(1'b1, 4'(i), 1'b0, 1'b0, 1'b1, 1'b0, 32'h21FEDCBA, 4'h2, 8'd5);
        add(1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h21FEDCBA, 4'h2, 8'd5);
        for (int i = 1; i < 9; i++) add(1'b1, 4'(i), 1'b0, 1'b0, 1'b1, 1'b0, 32'h21FEDCBA, 4'h2, 8'd5);
        add(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h87654321, 4'h8, 8'd5);
        add(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h87654321, 4'h8, 8'd6);

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; frame_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_fv", 0, 32'(frame_valid), 32'h0);
        chk("rst_fd", 0, frame_data, 32'h0);
        chk("rst_fp", 0, 32'(frame_parity), 32'h0);
        chk("rst_fc", 0, 32'(frame_count), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].iv, vq[i].d, vq[i].fl, vq[i].fr);
            @(negedge clock);
            chk("in_ready", i, 32'(in_ready), 32'(vq[i].e_ir));
            chk("frame_valid", i, 32'(frame_valid), 32'(vq[i].e_fv));
            chk("frame_data", i, frame_data, vq[i].e_fd);
            chk("frame_parity", i, 32'(frame_parity), 32'(vq[i].e_fp));
            chk("frame_count", i, 32'(frame_count), 32'(vq[i].e_fc));
        end

        // Asynchronous reset mid-cycle after 5 words.
        for (int i = 1; i < 6; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_fv", 0, 32'(frame_valid), 32'h0);
        chk("arst_fd", 0, frame_data, 32'h0);
        chk("arst_fp", 0, 32'(frame_parity), 32'h0);
        chk("arst_fc", 0, 32'(frame_count), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 1; i < 9; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        @(negedge clock);
        chk("post_rst_fv", 0, 32'(frame_valid), 32'h1);
        chk("post_rst_fd", 0, frame_data, 32'h87654321);
        chk("post_rst_fp", 0, 32'(frame_parity), 32'h8);
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clock);
        chk("post_rst_fc", 0, 32'(frame_count), 32'h1);

        // Frame count wrap over 256 frames.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int f = 1; f <= 256; f++) begin
            for (int w = 0; w < 8; w++) drive(1'b1, 4'(f + w), 1'b0, 1'b1);
            drive(1'b0, 4'h0, 1'b0, 1'b1);
            drive(1'b0, 4'h0, 1'b0, 1'b0);
            @(negedge clock);
            if (f == 255) chk("wrap_fc", f, 32'(frame_count), 32'd255);
            if (f == 256) chk("wrap_fc", f, 32'(frame_count), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
